booth_mul_arbiter: RTL and testbench
====================================

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 64, WAIT-cycle limit, used only under REQ-030.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port clear, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port req_valid, input, NREQ, per-requester operation request.
REQ-007 SHALL have port req_ready, output, NREQ, one-hot accept.
REQ-008 SHALL have port req_m / req_q, input, NREQ*WIDTH each, packed multiplicand / multiplier, slice i belonging to requester i.
REQ-009 SHALL have port resp_valid / resp_ready, output / input, 1 each, result handshake.
REQ-010 SHALL have port resp_id, output, clog2(NREQ), index of the served requester.
REQ-011 SHALL have port resp_data, output, 2*WIDTH, signed product.
REQ-012 SHALL have port resp_err, output, 1, timeout flag.
REQ-013 SHALL have multiplier-side ports mul_clear_n (out, 1, active-low), mul_start (out, 1), mul_m / mul_q (out, WIDTH each), mul_done (in, 1), mul_product (in, 2*WIDTH).

Function
REQ-014 SHALL implement the states IDLE, RST, ISSUE, WAIT, RESP.
REQ-015 IDLE: when any req_valid is high, SHALL assert req_ready for exactly one requester, chosen round-robin starting at ptr.
- Operands SHALL be captured into mul_m / mul_q on that edge.
- The index SHALL be latched into resp_id.
- Next state SHALL be RST.
REQ-016 req_ready SHALL be high only in IDLE, at most one bit, only for a requester whose req_valid is high.
REQ-017 RST: mul_clear_n SHALL be 0 for exactly one cycle; next state ISSUE.
REQ-018 ISSUE: mul_start SHALL be 1 for exactly one cycle; next state WAIT.
REQ-019 WAIT: on the first cycle mul_done is 1, SHALL register mul_product into resp_data and go to RESP.
REQ-020 RESP: resp_valid SHALL be 1 with resp_data and resp_id held stable until resp_ready is 1.
- On the edge where resp_ready is 1, SHALL go to IDLE and set ptr to (resp_id+1) mod NREQ.
REQ-021 Accept-to-start latency SHALL be exactly 2 cycles: accept at edge N, RST in cycle N+1, mul_start in cycle N+2.
REQ-022 Only one operation SHALL be in flight at a time; req_valid SHALL be ignored outside IDLE.
REQ-023 A requester dropping req_valid after acceptance SHALL NOT affect the operation in flight.
REQ-024 ptr wrap: after serving NREQ-1, ptr SHALL become 0.
REQ-025 A requester that holds req_valid continuously SHALL wait at most NREQ-1 other operations.
REQ-026 mul_done outside WAIT SHALL be ignored.

Reset
REQ-027 While clear is 1, the following SHALL hold:
- state = IDLE, ptr = 0;
- req_ready = 0, mul_start = 0, resp_valid = 0, resp_err = 0;
- resp_data = 0, resp_id = 0, mul_m = 0, mul_q = 0;
- mul_clear_n = 0, so the multiplier is held cleared.
REQ-028 clear asserted mid-operation (any state) SHALL abort the operation with no response issued.
REQ-029 After clear deasserts, the first accept SHALL NOT occur before the first rising edge.

Configuration
REQ-030 With MUL_ARB_TIMEOUT_EN defined, a WAIT-cycle counter SHALL be active.
- Reaching TIMEOUT cycles without mul_done SHALL force RESP with resp_err = 1 and resp_data = 0.
- resp_err SHALL clear on leaving RESP.
REQ-031 Without MUL_ARB_TIMEOUT_EN, WAIT SHALL be unbounded and resp_err SHALL be tied 0; the port SHALL remain present.

Structure
REQ-032 Package mul_arb_pkg SHALL hold the state typedef and encodings plus the default NREQ, WIDTH and TIMEOUT constants.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick, with inputs req vector and ptr and outputs one-hot grant and index.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Single op: req 0, m=3, q=-2 -> req_ready[0] 1 cycle; mul_clear_n low 1 cycle; mul_start 2 cycles after accept; resp_data=-6, resp_id=0.
- Fairness: all 4 req_valid held -> service order 0,1,2,3,0.
- Backpressure: resp_ready low 5 cycles -> resp_valid/resp_data stable; no new req_ready until resp_ready.
- Reset in WAIT: clear pulse -> no resp_valid; outputs at reset values; next request served by ptr=0 order.
- Timeout (macro on, TIMEOUT=8): mul_done never asserted -> resp_valid with resp_err=1, resp_data=0 after 8 WAIT cycles.
- Edge operands: m=-128, q=-128, WIDTH=8 -> resp_data=16384.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared state encoding and default sizing for booth_mul_arbiter and its round-robin picker.
package mul_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/booth_mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Scans requesters starting at ptr and
// returns the first active one as a one-hot grant plus its index.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CW   = IDXW + 1;
    localparam logic [CW-1:0] NREQ_W = CW'(NREQ);

    logic [CW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            // one extra bit so ptr+k never overflows before the modulo fold
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && req[cand[IDXW-1:0]]) begin
                grant[cand[IDXW-1:0]] = 1'b1;
                idx                   = cand[IDXW-1:0];
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin front end sharing one external multiplier among NREQ requesters.
// Optional macro MUL_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and reports resp_err.
module booth_mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_m,
    input  logic [NREQ*WIDTH-1:0]     req_q,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [2*WIDTH-1:0]        resp_data,
    output logic                      resp_err,
    output logic                      mul_clear_n,
    output logic                      mul_start,
    output logic [WIDTH-1:0]          mul_m,
    output logic [WIDTH-1:0]          mul_q,
    input  logic                      mul_done,
    input  logic [2*WIDTH-1:0]        mul_product,
    output state_t                    dbgState
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is offered only in IDLE to the picked requester; resp_valid holds with
    // stable resp_id/resp_data/resp_err until resp_ready completes the transfer.

    localparam int IDXW = $clog2(NREQ);

    state_t state, stateNext;

    logic [IDXW-1:0]    ptr;
    logic [IDXW-1:0]    pickIdx;
    logic [NREQ-1:0]    pickGrant;
    logic [IDXW-1:0]    respIdR;
    logic [WIDTH-1:0]   mulMR, mulQR;
    logic [2*WIDTH-1:0] respDataR;
    logic [WIDTH-1:0]   reqMArr [NREQ];
    logic [WIDTH-1:0]   reqQArr [NREQ];
    logic               accept;
    logic               timeoutHit;

    for (genvar i = 0; i < NREQ; i++) begin : gUnpack
        assign reqMArr[i] = req_m[i*WIDTH +: WIDTH];
        assign reqQArr[i] = req_q[i*WIDTH +: WIDTH];
    end

    rr_pick #(.NREQ(NREQ)) uPick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pickGrant),
        .idx   (pickIdx)
    );

    assign accept = (state == IDLE) && (|req_valid);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (|req_valid) stateNext = RST;
            RST:     stateNext = ISSUE;
            ISSUE:   stateNext = WAIT;
            WAIT:    if (mul_done || timeoutHit) stateNext = RESP;
            RESP:    if (resp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ptr       <= '0;
            respIdR   <= '0;
            mulMR     <= '0;
            mulQR     <= '0;
            respDataR <= '0;
        end else begin
            if (accept) begin
                mulMR   <= reqMArr[pickIdx];
                mulQR   <= reqQArr[pickIdx];
                respIdR <= pickIdx;
            end
            if (state == WAIT) begin
                if (mul_done) begin
                    respDataR <= mul_product;
                end else if (timeoutHit) begin
                    respDataR <= '0;
                end
            end
            if ((state == RESP) && resp_ready) begin
                ptr <= (respIdR == IDXW'(NREQ - 1)) ? '0 : respIdR + IDXW'(1);
            end
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] LAST_WAIT = CNTW'(TIMEOUT - 1);

    logic [CNTW-1:0] waitCnt;
    logic            respErrR;

    // waitCnt holds the number of WAIT cycles already spent before the current one
    assign timeoutHit = (state == WAIT) && !mul_done && (waitCnt == LAST_WAIT);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            waitCnt  <= '0;
            respErrR <= 1'b0;
        end else begin
            if ((state == WAIT) && (stateNext == WAIT)) begin
                waitCnt <= waitCnt + CNTW'(1);
            end else begin
                waitCnt <= '0;
            end
            if (timeoutHit) begin
                respErrR <= 1'b1;
            end else if ((state == RESP) && resp_ready) begin
                respErrR <= 1'b0;
            end
        end
    end

    assign resp_err = respErrR;
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT > 0);
    assign timeoutHit    = 1'b0;
    assign resp_err      = 1'b0;
`endif

    assign req_ready   = ((state == IDLE) && !clear) ? pickGrant : '0;
    assign mul_clear_n = !clear && (state != RST);
    assign mul_start   = (state == ISSUE);
    assign mul_m       = mulMR;
    assign mul_q       = mulQR;
    assign resp_valid  = (state == RESP);
    assign resp_id     = respIdR;
    assign resp_data   = respDataR;
    assign dbgState    = state;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed scenarios, a behavioural multiplier on the
// mul_* side, and a cycle model plus expected queue checked at every falling edge.
module tb_booth_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDXW  = 2;
    localparam int PW    = 2 * WIDTH;
`ifdef MUL_ARB_TIMEOUT_EN
    localparam int TMO    = 8;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 64;
    localparam bit TMO_EN = 1'b0;
`endif

    logic                  clk;
    logic                  clear;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_m, req_q;
    logic                  resp_valid, resp_ready;
    logic [IDXW-1:0]       resp_id;
    logic [PW-1:0]         resp_data;
    logic                  resp_err;
    logic                  mul_clear_n, mul_start;
    logic [WIDTH-1:0]      mul_m, mul_q;
    logic                  mul_done;
    logic [PW-1:0]         mul_product;
    state_t                dbg_state;

    booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_q(req_q),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err),
        .mul_clear_n(mul_clear_n), .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
        .mul_done(mul_done), .mul_product(mul_product), .dbgState(dbg_state)
    );

    // ---------------- clock / reset ----------------
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] sprod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return PW'(sa * sb);
    endfunction

    function automatic int rr_model(input logic [NREQ-1:0] rv, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (rv[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- behavioural multiplier ----------------
    int mul_lat     = 2;
    bit mul_hang    = 1'b0;
    bit inject_junk = 1'b0;

    initial begin : responder
        int cnt;
        logic [WIDTH-1:0] cm, cq;
        logic nd;
        logic [PW-1:0] np;
        cnt = -1; cm = '0; cq = '0; np = '0;
        mul_done = 1'b0; mul_product = '0;
        forever begin
            @(negedge clk);
            nd = 1'b0;
            if (!mul_clear_n) cnt = -1;
            else if (mul_start) begin cm = mul_m; cq = mul_q; cnt = mul_lat; end
            else if (cnt > 0) cnt--;
            if (cnt == 0 && !mul_hang) begin nd = 1'b1; np = sprod(cm, cq); cnt = -1; end
            else if (inject_junk) begin nd = 1'b1; np = 16'hDEAD; end
            @(posedge clk); #1;
            mul_done = nd;
            mul_product = np;
        end
    end

    // ---------------- model + scoreboard ----------------
    int m_phase = 0;   // 0 idle, 1 multiplier clear, 2 start, 3 waiting, 4 responding
    int m_ptr = 0, m_id = 0, m_wait = 0;
    logic m_err = 1'b0;
    logic [WIDTH-1:0] m_opm = '0, m_opq = '0;
    logic [PW-1:0] m_prod = '0;
    logic [IDXW+PW-1:0] exp_q[$];
    int served_q[$];

    always @(negedge clk) begin : compare
        int g;
        logic [NREQ-1:0] exp_ready;
        logic [IDXW+PW-1:0] e;
        if (clear) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_mul_start", 32'(mul_start), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_err", 32'(resp_err), 0);
            chk("rst_resp_data", 32'(resp_data), 0);
            chk("rst_resp_id", 32'(resp_id), 0);
            chk("rst_mul_m", 32'(mul_m), 0);
            chk("rst_mul_q", 32'(mul_q), 0);
            chk("rst_mul_clear_n", 32'(mul_clear_n), 0);
            chk("rst_state", 32'(dbg_state), 32'(IDLE));
            m_phase = 0; m_ptr = 0; m_wait = 0; m_err = 1'b0;
            exp_q.delete();
        end else begin
            g = (m_phase == 0) ? rr_model(req_valid, m_ptr) : -1;
            exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("mul_clear_n", 32'(mul_clear_n), 32'(m_phase != 1));
            chk("mul_start", 32'(mul_start), 32'(m_phase == 2));
            chk("resp_valid", 32'(resp_valid), 32'(m_phase == 4));
            chk("resp_err", 32'(resp_err), 32'(m_phase == 4 && m_err));
            if (m_phase == 2) begin
                chk("mul_m", 32'(mul_m), 32'(m_opm));
                chk("mul_q", 32'(mul_q), 32'(m_opq));
            end
            if (m_phase == 4) begin
                chk("resp_id", 32'(resp_id), 32'(m_id));
                chk("resp_data", 32'(resp_data), m_err ? 32'd0 : 32'(m_prod));
            end
            case (m_phase)
                0: if (g >= 0) begin
                    m_id = g;
                    m_opm = req_m[g*WIDTH +: WIDTH];
                    m_opq = req_q[g*WIDTH +: WIDTH];
                    m_prod = sprod(m_opm, m_opq);
                    exp_q.push_back({IDXW'(g), m_prod});
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: begin m_phase = 3; m_wait = 0; end
                3: if (mul_done) begin
                    m_phase = 4; m_err = 1'b0;
                end else begin
                    m_wait++;
                    if (TMO_EN && m_wait == TMO) begin m_phase = 4; m_err = 1'b1; end
                end
                4: if (resp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_queue_empty", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_err) e[PW-1:0] = '0;
                        chk("sb_id_data", 32'({resp_id, resp_data}), 32'(e));
                    end
                    served_q.push_back(int'(resp_id));
                    m_ptr = (m_id + 1) % NREQ;
                    m_phase = 0;
                    m_err = 1'b0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        req_m[i*WIDTH +: WIDTH] = m;
        req_q[i*WIDTH +: WIDTH] = q;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_accept(input int i, input string name, output int at);
        bit got;
        got = 1'b0; at = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin got = 1'b1; at = cyc; break; end
        end
        if (!got) chk({name, "_accept_timeout"}, 0, 1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(input string name, output int at);
        bit got;
        got = 1'b0; at = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; at = cyc; break; end
        end
        if (!got) chk({name, "_resp_timeout"}, 0, 1);
    endtask

    task automatic wait_start(input string name, output int at);
        bit got;
        got = 1'b0; at = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mul_start) begin got = 1'b1; at = cyc; break; end
        end
        if (!got) chk({name, "_start_timeout"}, 0, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stimulus
        int c0, c1, gi;
        bit got;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        req_valid = '0; req_m = '0; req_q = '0; resp_ready = 1'b1;
        clear = 1'b0;
        #1 clear = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("pin_reset_clear_n", 32'(mul_clear_n), 0);
        chk("pin_reset_data", 32'(resp_data), 0);
        tick();
        clear = 1'b0;

        // single op: 3 * -2
        mul_lat = 2;
        set_req(0, 8'd3, 8'hFE);
        wait_accept(0, "t1", c0);
        chk("pin_t1_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("pin_t1_rst", 32'(mul_clear_n), 0);
        wait_start("t1", c1);
        chk("pin_t1_latency", 32'(c1 - c0), 2);
        wait_resp("t1", c1);
        chk("pin_t1_data", 32'(resp_data), 32'h0000FFFA);
        chk("pin_t1_id", 32'(resp_id), 0);
        repeat (2) tick();

        // edge operands: -128 * -128
        set_req(1, 8'h80, 8'h80);
        wait_accept(1, "t2", c0);
        wait_resp("t2", c1);
        chk("pin_t2_data", 32'(resp_data), 32'h00004000);
        chk("pin_t2_id", 32'(resp_id), 1);
        repeat (2) tick();

        // clear pulse while waiting on the multiplier
        mul_hang = 1'b1;
        set_req(2, 8'd5, 8'd7);
        wait_accept(2, "t3", c0);
        repeat (6) tick();
        clear = 1'b1;
        @(negedge clk);
        chk("pin_t3_mul_m", 32'(mul_m), 0);
        chk("pin_t3_resp_id", 32'(resp_id), 0);
        tick();
        clear = 1'b0;
        mul_hang = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("pin_t3_noresp", 32'(resp_valid), 0);
        end
        tick();

        // fairness: all requesters held
        served_q.delete();
        mul_lat = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'(-(i + 3)));
        for (int n = 0; n < 5; n++) begin
            got = 1'b0;
            for (int w = 0; w < 60; w++) begin
                @(negedge clk);
                if (req_ready != '0) begin got = 1'b1; break; end
            end
            if (!got) chk("fair_accept_timeout", 0, 1);
            gi = -1;
            for (int b = 0; b < NREQ; b++) if (req_ready[b]) gi = b;
            chk("pin_fair_order", 32'(gi), 32'(exp_order[n]));
        end
        tick();
        req_valid = '0;
        wait_resp("fair", c1);
        repeat (2) tick();
        chk("pin_fair_served", 32'(served_q.size()), 5);
        for (int n = 0; n < 5 && n < served_q.size(); n++) begin
            chk("pin_fair_served_id", 32'(served_q[n]), 32'(exp_order[n]));
        end

        // backpressure with a stray mul_done during RESP
        mul_lat = 1;
        resp_ready = 1'b0;
        set_req(0, 8'd10, 8'd12);
        wait_accept(0, "t5", c0);
        set_req(1, 8'hF9, 8'd9);
        wait_resp("t5", c1);
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            chk("pin_t5_valid", 32'(resp_valid), 1);
            chk("pin_t5_data", 32'(resp_data), 32'h00000078);
            chk("pin_t5_no_ready", 32'(req_ready), 0);
            if (n == 0) inject_junk = 1'b1;
            if (n == 3) inject_junk = 1'b0;
        end
        tick();
        inject_junk = 1'b0;
        resp_ready = 1'b1;
        wait_accept(1, "t5b", c0);
        wait_resp("t5b", c1);
        chk("pin_t5b_data", 32'(resp_data), 32'h0000FFC1);
        chk("pin_t5b_id", 32'(resp_id), 1);
        repeat (2) tick();

`ifdef MUL_ARB_TIMEOUT_EN
        // multiplier never answers
        mul_hang = 1'b1;
        set_req(2, 8'd1, 8'd1);
        wait_accept(2, "t6", c0);
        wait_start("t6", c0);
        wait_resp("t6", c1);
        chk("pin_t6_wait_cycles", 32'(c1 - c0), 32'(TMO + 1));
        chk("pin_t6_err", 32'(resp_err), 1);
        chk("pin_t6_data", 32'(resp_data), 0);
        tick();
        @(negedge clk);
        chk("pin_t6_err_cleared", 32'(resp_err), 0);
        mul_hang = 1'b0;
        repeat (2) tick();
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
